// File: rtl/alu_issue_stage.sv
// Purpose: queues ALU requests, presents the FIFO head to a combinational alu and registers its result.
// Latency: a request accepted at edge N shows on out_* after edge N+1 (empty pipe); throughput 1 op/cycle.
// Backpressure: in_ready drops when the FIFO is full; the result register holds while out_valid & !out_ready.
module alu_issue_stage #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_src1,
  input  logic [DATA_W-1:0]          in_src2,
  input  logic [3:0]                 in_ctrl,
  output logic [DATA_W-1:0]          alu_src1,
  output logic [DATA_W-1:0]          alu_src2,
  output logic [3:0]                 alu_ctrl,
  input  logic [DATA_W-1:0]          alu_result,
  input  logic                       alu_zero,
  input  logic                       alu_cout,
  input  logic                       alu_overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_result,
  output logic [2:0]                 out_zcv,
  output logic [3:0]                 out_ctrl,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W-1:0] mem_src1 [DEPTH];
  logic [DATA_W-1:0] mem_src2 [DEPTH];
  logic [3:0]        mem_ctrl [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic       not_empty;
  logic       push;
  logic       issue;
  logic       arith;
  logic       illegal_next;
  logic [2:0] zcv_next;

  assign not_empty  = (count != '0);
  assign in_ready   = (count != FULL);
  assign push       = in_valid & in_ready;
  assign issue      = not_empty & (~out_valid | out_ready);
  assign fifo_count = count;

  // Head entry drives the alu; idle inputs are held at zero so the alu sees no stale op.
  assign alu_src1 = not_empty ? mem_src1[rd_ptr] : '0;
  assign alu_src2 = not_empty ? mem_src2[rd_ptr] : '0;
  assign alu_ctrl = not_empty ? mem_ctrl[rd_ptr] : 4'd0;

  // Decode the head op: carry/overflow only mean something for ADD/SUB; flag unsupported codes.
  always_comb begin
    arith        = 1'b0;
    illegal_next = 1'b0;
    case (alu_ctrl)
      4'd2, 4'd6:        arith = 1'b1;
      4'd0, 4'd1, 4'd7,
      4'd12:             arith = 1'b0;
      default:           illegal_next = 1'b1;
    endcase
    zcv_next = {alu_zero, arith ? {alu_cout, alu_overflow} : 2'b00};
  end

  // FIFO storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_src1[wr_ptr] <= in_src1;
      mem_src2[wr_ptr] <= in_src2;
      mem_ctrl[wr_ptr] <= in_ctrl;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Result register: load on issue, otherwise release on consume while keeping the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zcv     <= 3'b000;
      out_ctrl    <= 4'd0;
      out_illegal <= 1'b0;
    end else if (issue) begin
      out_valid   <= 1'b1;
      out_result  <= alu_result;
      out_zcv     <= zcv_next;
      out_ctrl    <= alu_ctrl;
      out_illegal <= illegal_next;
    end else if (out_valid & out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural stand-in for the combinational alu.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// force_cv drives alu cout/overflow high regardless of op, to exercise flag masking.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [3:0]  in_ctrl;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_cout;
  logic        alu_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_zcv;
  logic [3:0]  out_ctrl;
  logic        out_illegal;
  logic [2:0]  fifo_count;
  logic        force_cv;

  int vectors = 0;
  int miscompares = 0;

  alu_issue_stage #(.DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_ctrl(in_ctrl),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zcv(out_zcv), .out_ctrl(out_ctrl),
    .out_illegal(out_illegal), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Combinational alu stand-in
  logic [32:0] sum;
  always_comb begin
    sum          = '0;
    alu_result   = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'd0:  alu_result = alu_src1 & alu_src2;
      4'd1:  alu_result = alu_src1 | alu_src2;
      4'd2: begin
        sum          = {1'b0, alu_src1} + {1'b0, alu_src2};
        alu_result   = sum[31:0];
        alu_cout     = sum[32];
        alu_overflow = (alu_src1[31] == alu_src2[31]) && (sum[31] != alu_src1[31]);
      end
      4'd6: begin
        sum          = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
        alu_result   = sum[31:0];
        alu_cout     = sum[32];
        alu_overflow = (alu_src1[31] != alu_src2[31]) && (sum[31] != alu_src1[31]);
      end
      4'd7:  alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      4'd12: alu_result = ~(alu_src1 | alu_src2);
      default: alu_result = alu_src1 ^ alu_src2;
    endcase
    if (force_cv) begin
      alu_cout     = 1'b1;
      alu_overflow = 1'b1;
    end
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    in_valid = v;
    in_src1  = a;
    in_src2  = b;
    in_ctrl  = c;
  endtask

  // Push one op with an empty pipe and out_ready=1; result is visible after the second edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    drive(1'b1, a, b, c);
    tick();
    drive(1'b0, 32'd0, 32'd0, 4'd0);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    force_cv  = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 4'd0);
    #12;
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_out_valid",   32'(out_valid), 32'd0);
    chk("rst_fifo_count",  32'(fifo_count), 32'd0);
    chk("rst_in_ready",    32'(in_ready), 32'd1);
    chk("rst_out_result",  out_result, 32'd0);
    chk("rst_out_zcv",     32'(out_zcv), 32'd0);
    chk("rst_out_ctrl",    32'(out_ctrl), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    chk("rst_alu_src1",    alu_src1, 32'd0);

    // 1. Reset mid-queue: 3 pushes with out_ready=0 -> one captured, two queued
    drive(1'b1, 32'd1, 32'd2, 4'd2); tick();
    drive(1'b1, 32'd3, 32'd4, 4'd2); tick();
    drive(1'b1, 32'd5, 32'd6, 4'd2); tick();
    drive(1'b0, 32'd0, 32'd0, 4'd0);
    chk("pre_rst_count", 32'(fifo_count), 32'd2);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_alu_src1", alu_src1, 32'd3);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_count",     32'(fifo_count), 32'd0);
    chk("async_rst_in_ready",  32'(in_ready), 32'd1);
    chk("async_rst_alu_src1",  alu_src1, 32'd0);
    chk("async_rst_alu_src2",  alu_src2, 32'd0);
    chk("async_rst_alu_ctrl",  32'(alu_ctrl), 32'd0);
    chk("async_rst_out_result", out_result, 32'd0);
    #2 rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    // 2. ADD ops
    out_ready = 1'b1;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 4'd2);
    chk("add_ovf_valid",  32'(out_valid), 32'd1);
    chk("add_ovf_result", out_result, 32'h8000_0000);
    chk("add_ovf_zcv",    32'(out_zcv), 32'b001);
    chk("add_ovf_ctrl",   32'(out_ctrl), 32'd2);
    chk("add_ovf_illegal", 32'(out_illegal), 32'd0);
    chk("add_ovf_count",  32'(fifo_count), 32'd0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'd2);
    chk("add_wrap_result", out_result, 32'd0);
    chk("add_wrap_zcv",    32'(out_zcv), 32'b110);

    // 3. SUB 5-5
    run_op(32'd5, 32'd5, 4'd6);
    chk("sub_eq_result", out_result, 32'd0);
    chk("sub_eq_zcv",    32'(out_zcv), 32'b110);
    chk("sub_eq_ctrl",   32'(out_ctrl), 32'd6);

    // 4. AND with alu carry/overflow forced high -> masked
    force_cv = 1'b1;
    run_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd0);
    chk("and_mask_result", out_result, 32'd0);
    chk("and_mask_zcv",    32'(out_zcv), 32'b100);
    force_cv = 1'b0;
    tick();
    chk("drain_idle_valid", 32'(out_valid), 32'd0);

    // 5. Backpressure: DEPTH+1 pushes with out_ready=0
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h10 + 32'(i), 32'd0, 4'd2);
      tick();
    end
    chk("bp_count",    32'(fifo_count), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_result",   out_result, 32'h10);
    drive(1'b1, 32'h15, 32'd0, 4'd2);
    tick();
    chk("bp_hold_count",  32'(fifo_count), 32'd4);
    chk("bp_hold_result", out_result, 32'h10);
    chk("bp_hold_valid",  32'(out_valid), 32'd1);
    drive(1'b0, 32'd0, 32'd0, 4'd0);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("bp_drain_valid",  32'(out_valid), 32'd1);
      chk("bp_drain_result", out_result, 32'h10 + 32'(i));
    end
    tick();
    chk("bp_drain_end_valid", 32'(out_valid), 32'd0);
    chk("bp_drain_end_count", 32'(fifo_count), 32'd0);

    // 6. Full boundary, illegal op captured first
    out_ready = 1'b0;
    drive(1'b1, 32'h20, 32'h01, 4'd3); tick();
    for (int i = 1; i < 5; i++) begin
      drive(1'b1, 32'h30 + 32'(i), 32'd0, 4'd2);
      tick();
    end
    chk("full_count",   32'(fifo_count), 32'd4);
    chk("ill_flag",     32'(out_illegal), 32'd1);
    chk("ill_ctrl",     32'(out_ctrl), 32'd3);
    chk("ill_result",   out_result, 32'h21);
    chk("ill_zcv",      32'(out_zcv), 32'b000);
    drive(1'b1, 32'h40, 32'd0, 4'd2);
    out_ready = 1'b1;
    tick();
    chk("full_pop_only_count",  32'(fifo_count), 32'd3);
    chk("full_pop_only_result", out_result, 32'h31);
    chk("full_pop_only_ill",    32'(out_illegal), 32'd0);
    chk("full_pop_only_ready",  32'(in_ready), 32'd1);
    tick();
    chk("push_pop_count",  32'(fifo_count), 32'd3);
    chk("push_pop_result", out_result, 32'h32);
    drive(1'b0, 32'd0, 32'd0, 4'd0);
    tick(); chk("full_drain_0", out_result, 32'h33);
    tick(); chk("full_drain_1", out_result, 32'h34);
    tick(); chk("full_drain_2", out_result, 32'h40);
    chk("full_drain_2_valid", 32'(out_valid), 32'd1);
    tick();
    chk("full_drain_end_valid", 32'(out_valid), 32'd0);
    chk("full_drain_end_count", 32'(fifo_count), 32'd0);
    chk("idle_alu_ctrl", 32'(alu_ctrl), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
